clint_bus_arbiter: RTL
======================

Name: clint_bus_arbiter

Overview:
- Round-robin arbiter that shares the single CLINT MMIO slave port (msip, mtimecmp, mtime) between NUM_REQ requesters, for example harts and a debug/DMA master.
- Serialises accesses and registers the granted request so the CLINT sees stable addr/wmask/wdata.
- Forces one idle cycle between transactions, so the CLINT's registered ready cannot leak to the next grantee.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- TIMEOUT_CYCLES, 255, grant cycles without clint_ready before a forced completion (used only with the optional feature)

Ports:
- clk  input  1  clock
- resetn  input  1  synchronous, active-low reset
- req_valid  input  NUM_REQ  per-requester access request
- req_addr  input  NUM_REQ*32  packed byte addresses; requester i occupies bits [32i+31:32i]
- req_wmask  input  NUM_REQ*4  packed byte write enables; 0 = read
- req_wdata  input  NUM_REQ*32  packed write data
- req_ready  output  NUM_REQ  one-cycle completion pulse to the granted requester
- req_rdata  output  32  read data, shared; valid only when the matching req_ready bit is set
- req_err  output  NUM_REQ  one-cycle timeout-completion pulse
- clint_valid  output  1  request to CLINT
- clint_addr  output  32  registered address
- clint_wmask  output  4  registered write mask
- clint_wdata  output  32  registered write data
- clint_rdata  input  32  CLINT read data; combinational on addr
- clint_ready  input  1  CLINT completion; registered, arrives 1 cycle after valid

Behaviour:
- Reset values: state IDLE; clint_valid=0; clint_addr/wmask/wdata=0; req_ready=0; req_err=0; rr pointer=NUM_REQ-1, so requester 0 wins the first grant; timeout counter=0.
- States:
  - IDLE: if any req_valid, select the winner and register its addr/wmask/wdata and grant index, then go to GRANT; otherwise stay in IDLE.
  - GRANT: clint_valid=1. When clint_ready=1, drive req_ready[grant]=1 with req_rdata=clint_rdata in that same cycle (combinational pass-through), set pointer=grant, then go to DRAIN.
  - DRAIN: clint_valid=0; clint_ready is ignored (it is stale). Arbitrate exactly as in IDLE and go to GRANT or IDLE.
- Round-robin selection: the first index with req_valid set, scanning pointer+1, pointer+2, … modulo NUM_REQ.
- Latency: req_valid at cycle 0 (in IDLE) → clint_valid at cycle 1 → req_ready at cycle 2 → DRAIN at cycle 3.
  - Back-to-back throughput is one transaction per 3 cycles.
- Requester contract:
  - Hold the request until req_ready.
  - req_valid still high in the cycle after req_ready counts as a new request.
  - Dropping req_valid mid-grant does not abort the access; it still completes and req_ready still pulses.
- clint_addr, clint_wmask and clint_wdata are constant for the whole of GRANT.
- Outputs are undefined when NUM_REQ=1 only in the sense that the pointer logic degenerates; a single requester is always selected.
- req_rdata=0 whenever no req_ready bit is set.
- At most one req_ready/req_err bit is set in any cycle.
- Reset mid-transaction: state returns to IDLE next cycle and no req_ready is issued. The CLINT's own ready also clears under the shared reset.

Optional Feature:
- Macro CLINT_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs during GRANT.
  - If it reaches TIMEOUT_CYCLES without clint_ready, pulse req_ready[grant] and req_err[grant] together with req_rdata=0, then go to DRAIN.
  - This covers an address that misses the CLINT decode, which otherwise never responds.
  - The counter clears on every entry to GRANT.
- Undefined: no counter; req_err is tied to 0; an unmapped address stalls the grant indefinitely, and upstream decode must prevent it.

Decomposition:
- Package clint_arb_pkg:
  - state encoding (IDLE, GRANT, DRAIN);
  - CLINT address constants: MSIP 0x1100_0000, MTIMECMPL 0x1100_4000, MTIMECMPH 0x1100_4004, MTIMEL 0x1100_BFF8, MTIMEH 0x1100_BFFC;
  - default timeout value.
- Sub-module clint_arb_rr_pick: combinational round-robin picker; inputs req vector and pointer; outputs winner index and any_req.

Test Plan:
- Single read: req0 reads 0x1100_BFF8 with clint_ready at cycle 2 and clint_rdata=0x0000_0123 → req_ready[0] at cycle 2, req_rdata=0x123, clint_valid low at cycle 3.
- Contention: req0 and req1 hold valid continuously → grants alternate 0,1,0,1; four transactions complete in 12 cycles; clint_addr stable through every GRANT.
- Write: req1 writes 0x1100_4004, wmask=0xF, data 0xDEAD_BEEF → clint_wmask=0xF, clint_wdata=0xDEADBEEF; req_ready[1] pulses once.
- Stale ready: CLINT model holds ready high through DRAIN → no extra req_ready; the next grant completes only on a fresh ready.
- Reset during GRANT: resetn low at cycle 1 → cycle 2 has clint_valid=0, req_ready=0, and requester 0 wins first after reset.
- CLINT_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4: address 0x1100_0008 never acknowledged → req_ready[0] and req_err[0] pulse 4 cycles into GRANT with req_rdata=0; the next request is served normally.

Source files
------------

// File: rtl/clint_arb_pkg.sv
// rtl/clint_arb_pkg.sv - shared types and CLINT address map for the CLINT bus arbiter
package clint_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_DRAIN
    } arb_state_t;

    localparam logic [31:0] CLINT_MSIP      = 32'h1100_0000;
    localparam logic [31:0] CLINT_MTIMECMPL = 32'h1100_4000;
    localparam logic [31:0] CLINT_MTIMECMPH = 32'h1100_4004;
    localparam logic [31:0] CLINT_MTIMEL    = 32'h1100_BFF8;
    localparam logic [31:0] CLINT_MTIMEH    = 32'h1100_BFFC;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    // Index width that stays at least one bit for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clint_bus_arbiter_if.sv
// rtl/clint_bus_arbiter_if.sv - requester-side and CLINT-side bus interfaces of the arbiter
interface clint_req_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*32-1:0] req_addr;
    logic [NUM_REQ*4-1:0]  req_wmask;
    logic [NUM_REQ*32-1:0] req_wdata;
    logic [NUM_REQ-1:0]    req_ready;
    logic [31:0]           req_rdata;
    logic [NUM_REQ-1:0]    req_err;

    modport master (
        output req_valid, req_addr, req_wmask, req_wdata,
        input  req_ready, req_rdata, req_err
    );

    modport slave (
        input  req_valid, req_addr, req_wmask, req_wdata,
        output req_ready, req_rdata, req_err
    );
endinterface

interface clint_mmio_if;
    logic        clint_valid;
    logic [31:0] clint_addr;
    logic [3:0]  clint_wmask;
    logic [31:0] clint_wdata;
    logic [31:0] clint_rdata;
    logic        clint_ready;

    modport master (
        output clint_valid, clint_addr, clint_wmask, clint_wdata,
        input  clint_rdata, clint_ready
    );

    modport slave (
        input  clint_valid, clint_addr, clint_wmask, clint_wdata,
        output clint_rdata, clint_ready
    );
endinterface

// File: rtl/clint_arb_rr_pick.sv
// rtl/clint_arb_rr_pick.sv - combinational round-robin picker starting after the pointer
module clint_arb_rr_pick
    import clint_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDXW    = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDXW-1:0]    ptr,
    output logic [IDXW-1:0]    winner,
    output logic               any_req
);

    logic [IDXW-1:0] cand;

    // Scan from the farthest offset down so the nearest requester after ptr wins.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = IDXW'((int'(ptr) + off) % NUM_REQ);
            if (req[cand]) begin
                winner  = cand;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/clint_bus_arbiter.sv
// rtl/clint_bus_arbiter.sv - round-robin CLINT MMIO arbiter; optional grant timeout via CLINT_ARB_TIMEOUT_EN
module clint_bus_arbiter
    import clint_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic          clk,
    input  logic          resetn,
    clint_req_if.slave    req,
    clint_mmio_if.master  clint
);

    localparam int IDXW = idx_width(NUM_REQ);

    arb_state_t      state, state_nxt;
    logic [IDXW-1:0] grant_q, ptr_q, winner;
    logic            any_req, load, done, timeout;
    logic [31:0]     addr_q, wdata_q, sel_addr, sel_wdata;
    logic [3:0]      wmask_q, sel_wmask;

    clint_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_pick (
        .req     (req.req_valid),
        .ptr     (ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

`ifdef CLINT_ARB_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT_CYCLES - 1);

    logic [CNTW-1:0] cnt_q;

    assign timeout = (state == ST_GRANT) && !clint.clint_ready && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (state == ST_GRANT && cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign timeout        = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    assign done = (state == ST_GRANT) && (clint.clint_ready || timeout);

    always_comb begin
        sel_addr  = '0;
        sel_wmask = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == IDXW'(i)) begin
                sel_addr  = req.req_addr[32*i +: 32];
                sel_wmask = req.req_wmask[4*i +: 4];
                sel_wdata = req.req_wdata[32*i +: 32];
            end
        end
    end

    // DRAIN re-arbitrates like IDLE but ignores the CLINT's now-stale ready.
    always_comb begin
        state_nxt       = state;
        load            = 1'b0;
        req.req_ready   = '0;
        req.req_err     = '0;
        req.req_rdata   = '0;
        case (state)
            ST_IDLE, ST_DRAIN: begin
                if (any_req) begin
                    load      = 1'b1;
                    state_nxt = ST_GRANT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (done) begin
                    state_nxt              = ST_DRAIN;
                    req.req_ready[grant_q] = 1'b1;
                    if (timeout) begin
                        req.req_err[grant_q] = 1'b1;
                    end else begin
                        req.req_rdata = clint.clint_rdata;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= IDXW'(NUM_REQ - 1);
            addr_q  <= '0;
            wmask_q <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                grant_q <= winner;
                addr_q  <= sel_addr;
                wmask_q <= sel_wmask;
                wdata_q <= sel_wdata;
            end
            if (done) begin
                ptr_q <= grant_q;
            end
        end
    end

    assign clint.clint_valid = (state == ST_GRANT);
    assign clint.clint_addr  = addr_q;
    assign clint.clint_wmask = wmask_q;
    assign clint.clint_wdata = wdata_q;

endmodule
